perf_counter_ctrl: RTL and testbench
====================================

Name: perf_counter_ctrl

Overview:
- Owns and sequences the bank of performance counters that the MMIO counter decoder reads and clears: I-cache, D-cache and L2 hits and misses, branches, mispredictions and stalls.
- Accepts per-event increment pulses from the pipeline and caches, and per-counter clear strobes from the MMIO decoder (STI writes to 0xFFF7-0xFFFF).
- Also provides a sequenced clear-all sweep, a freeze control, and an atomic snapshot so software reads a coherent set.

Parameters:
- NUM_CTRS, 9, number of counters; index 0 = I-cache hits ... index 8 = stalls (MMIO order 0xFFFF downward).
- WIDTH, 16, counter width in bits (lc3b_word).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- event_inc  in  NUM_CTRS  per-counter increment pulse; +1 per cycle high
- clear_req  in  NUM_CTRS  per-counter clear strobe from MMIO decoder
- clear_all  in  1  start clear-all sweep
- freeze  in  1  when high, all increments are suppressed
- snap_req  in  1  capture all counters into the snapshot bank
- count_out  out  NUM_CTRS*WIDTH  live counter values; counter i at bits [i*WIDTH +: WIDTH]
- snap_out  out  NUM_CTRS*WIDTH  snapshot bank, same packing
- snap_valid  out  1  one-cycle pulse, snapshot updated
- ovf  out  NUM_CTRS  sticky overflow flag per counter
- busy  out  1  clear-all sweep in progress

Behaviour:
- Reset (rst high at a clk edge):
  - counters, snapshot bank and ovf = 0
  - snap_valid = 0, busy = 0, FSM = IDLE, sweep index = 0
  - reset mid-sweep aborts the sweep immediately
- Per-counter update priority at each clk edge: rst > sweep clear of this index > clear_req[i] > freeze > event_inc[i].
- A clear of either kind:
  - sets counter i to 0 and clears ovf[i]
  - drops a same-cycle event_inc[i] (result is 0, not 1)
- Increment: counter i += 1 when event_inc[i] and not freeze and no clear applies to i. Counters are independent; any subset may increment in the same cycle.
- Overflow, increment at 2^WIDTH-1:
  - ovf[i] set (sticky)
  - value per the optional feature below
- FSM, state IDLE:
  - busy = 0
  - clear_all moves to SWEEP with idx = 0
- FSM, state SWEEP:
  - busy = 1; counter idx cleared this cycle, then idx += 1
  - after idx = NUM_CTRS-1 is cleared, return to IDLE; busy drops the following cycle
  - total busy duration is exactly NUM_CTRS cycles
- Sweep interactions:
  - clear_all while in SWEEP is ignored, with no restart
  - counters already swept may count again during the sweep
  - clear_req and freeze remain effective during the sweep
- Snapshot timing:
  - snap_req sampled at edge N copies the pre-update counter values (those visible on count_out during the cycle of the request) into snap_out
  - snap_valid is high for exactly the cycle after edge N
  - back-to-back snap_req gives a new capture every cycle, with snap_valid held high
- Snapshot independence: the snapshot bank is never affected by clears or the sweep, only by rst and snap_req.
- count_out is registered, zero combinational path from inputs.

Optional Feature:
- Macro: PERF_CTR_SAT_EN.
- Defined: counters saturate at 2^WIDTH-1, further increments hold the value, and ovf[i] sets on the first blocked increment.
- Undefined: counters wrap 2^WIDTH-1 -> 0, and ovf[i] sets on the wrap.
- Clear behaviour is identical in both builds.

Test Plan:
- rst, then event_inc[0] high for 5 cycles -> count_out[0] = 5, all other counters 0, ovf = 0.
- Counter 3 at 7, clear_req[3] and event_inc[3] in the same cycle -> counter 3 = 0 next cycle, not 1.
- Counter 2 preloaded by 0xFFFF increments, one more increment -> SAT_EN: 0xFFFF with ovf[2] = 1; no SAT_EN: 0x0000 with ovf[2] = 1; clear_req[2] -> ovf[2] = 0.
- All counters at 10, clear_all, event_inc[0] held high -> busy high for 9 cycles, counter k zeroed in sweep cycle k, counter 0 = 8 when busy drops; second clear_all mid-sweep ignored.
- Counters at 4, event_inc all high, snap_req for 1 cycle -> snap_out all 4, snap_valid high 1 cycle, count_out all 5; later clear_all leaves snap_out unchanged.
- freeze high with event_inc high for 10 cycles -> counters unchanged; rst asserted mid-sweep -> busy = 0 and all counters 0 next cycle.

Source files
------------

// File: rtl/perf_counter_ctrl.sv
// ============================================================================
// Module   : perf_counter_ctrl
// Purpose  : Performance counter bank with per-counter clear, clear-all sweep,
//            freeze and atomic snapshot. Optional macro PERF_CTR_SAT_EN makes
//            counters saturate instead of wrapping.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module perf_counter_ctrl #(
    parameter int NUM_CTRS = 9,
    parameter int WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CTRS-1:0]       event_inc,
    input  logic [NUM_CTRS-1:0]       clear_req,
    input  logic                      clear_all,
    input  logic                      freeze,
    input  logic                      snap_req,
    output logic [NUM_CTRS*WIDTH-1:0] count_out,
    output logic [NUM_CTRS*WIDTH-1:0] snap_out,
    output logic                      snap_valid,
    output logic [NUM_CTRS-1:0]       ovf,
    output logic                      busy
);

    localparam int                IDX_W      = (NUM_CTRS > 1) ? $clog2(NUM_CTRS) : 1;
    localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(NUM_CTRS - 1);
    localparam logic [WIDTH-1:0]  c_MAX      = {WIDTH{1'b1}};
    localparam logic [0:0]        c_IDLE     = 1'b0;
    localparam logic [0:0]        c_SWEEP    = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [NUM_CTRS-1:0] w_sweep_clr;
    logic                r_snap_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // clear_all is only honoured from IDLE, so a request mid-sweep never restarts it
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            c_IDLE: begin
                if (clear_all) begin
                    w_state_nxt = c_SWEEP;
                    w_idx_nxt   = '0;
                end
            end
            c_SWEEP: begin
                if (r_idx == c_LAST_IDX) begin
                    w_state_nxt = c_IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        busy        = (r_state == c_SWEEP);
        w_sweep_clr = '0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            w_sweep_clr[i] = (r_state == c_SWEEP) && (r_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap_valid <= 1'b0;
        end else begin
            r_snap_valid <= snap_req;
        end
    end

    assign snap_valid = r_snap_valid;

    generate
        for (genvar g = 0; g < NUM_CTRS; g++) begin : g_ctr
            logic [WIDTH-1:0] r_cnt;
            logic [WIDTH-1:0] r_snap;
            logic             r_ovf;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else if (w_sweep_clr[g] || clear_req[g]) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else if (!freeze && event_inc[g]) begin
                    if (r_cnt == c_MAX) begin
                        r_ovf <= 1'b1;
                    end
`ifdef PERF_CTR_SAT_EN
                    if (r_cnt != c_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`else
                    r_cnt <= r_cnt + 1'b1;
`endif
                end
            end

            // Snapshot captures pre-update values and ignores every kind of clear
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_snap <= '0;
                end else if (snap_req) begin
                    r_snap <= r_cnt;
                end
            end

            assign count_out[g*WIDTH +: WIDTH] = r_cnt;
            assign snap_out[g*WIDTH +: WIDTH]  = r_snap;
            assign ovf[g]                      = r_ovf;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_perf_counter_ctrl.sv
// ============================================================================
// Module   : tb_perf_counter_ctrl
// Purpose  : Randomized and directed self-checking bench for perf_counter_ctrl.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_perf_counter_ctrl;

    localparam int N  = 9;
    localparam int W  = 16;
    localparam int PW = N * W;
    localparam int unsigned MAXV = (1 << W) - 1;
`ifdef PERF_CTR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  event_inc = '0;
    logic [N-1:0]  clear_req = '0;
    logic          clear_all = 1'b0;
    logic          freeze = 1'b0;
    logic          snap_req = 1'b0;
    logic [PW-1:0] count_out;
    logic [PW-1:0] snap_out;
    logic          snap_valid;
    logic [N-1:0]  ovf;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain integer counters and a sweep position (-1 = idle)
    int unsigned m_cnt [N];
    int unsigned m_snap[N];
    bit          m_ovf [N];
    bit          m_sv;
    int          m_sw;

    perf_counter_ctrl #(.NUM_CTRS(N), .WIDTH(W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .event_inc  (event_inc),
        .clear_req  (clear_req),
        .clear_all  (clear_all),
        .freeze     (freeze),
        .snap_req   (snap_req),
        .count_out  (count_out),
        .snap_out   (snap_out),
        .snap_valid (snap_valid),
        .ovf        (ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_update(input bit r, input logic [N-1:0] inc, input logic [N-1:0] clr,
                                input bit ca, input bit fz, input bit sr);
        if (r) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 0; m_snap[i] = 0; m_ovf[i] = 0;
            end
            m_sv = 0;
            m_sw = -1;
            return;
        end
        if (sr) for (int i = 0; i < N; i++) m_snap[i] = m_cnt[i];
        m_sv = sr;
        for (int i = 0; i < N; i++) begin
            if (i == m_sw || clr[i]) begin
                m_cnt[i] = 0;
                m_ovf[i] = 0;
            end else if (!fz && inc[i]) begin
                if (m_cnt[i] == MAXV) begin
                    m_ovf[i] = 1;
                    m_cnt[i] = SAT ? MAXV : 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
        if (m_sw >= 0) m_sw = (m_sw == N - 1) ? -1 : m_sw + 1;
        else if (ca)   m_sw = 0;
    endtask

    task automatic compare_all();
        logic [PW-1:0] ec, es;
        logic [N-1:0]  eo;
        for (int i = 0; i < N; i++) begin
            ec[i*W +: W] = W'(m_cnt[i]);
            es[i*W +: W] = W'(m_snap[i]);
            eo[i]        = m_ovf[i];
        end
        chk("count_out",  count_out, ec);
        chk("snap_out",   snap_out,  es);
        chk("ovf",        PW'(ovf),  PW'(eo));
        chk("snap_valid", PW'(snap_valid), PW'(m_sv));
        chk("busy",       PW'(busy), PW'(m_sw >= 0));
    endtask

    task automatic step(input bit r, input logic [N-1:0] inc, input logic [N-1:0] clr,
                        input bit ca, input bit fz, input bit sr);
        @(negedge clk);
        rst = r; event_inc = inc; clear_req = clr;
        clear_all = ca; freeze = fz; snap_req = sr;
        @(posedge clk);
        model_update(r, inc, clr, ca, fz, sr);
        #1;
        compare_all();
    endtask

    function automatic logic [W-1:0] ctr(input int i);
        return count_out[i*W +: W];
    endfunction

    initial begin
        logic [N-1:0] allv;
        logic [N-1:0] one;
        logic [PW-1:0] snap_hold;
        int nb;
        allv = '1;
        m_sw = -1;
        m_sv = 0;

        // Reset state
        step(1, '0, '0, 0, 0, 0);
        step(0, '0, '0, 0, 0, 0);
        chk("rst_count", count_out, '0);

        // Five increments of counter 0
        for (int k = 0; k < 5; k++) step(0, N'(1), '0, 0, 0, 0);
        chk("five_inc", PW'(ctr(0)), PW'(5));
        chk("five_ovf", PW'(ovf), '0);

        // Clear beats a same-cycle increment
        one = N'(1) << 3;
        for (int k = 0; k < 7; k++) step(0, one, '0, 0, 0, 0);
        chk("ctr3_seven", PW'(ctr(3)), PW'(7));
        step(0, one, one, 0, 0, 0);
        chk("clr_vs_inc", PW'(ctr(3)), '0);

        // Overflow of counter 2
        step(1, '0, '0, 0, 0, 0);
        one = N'(1) << 2;
        for (int k = 0; k < 65535; k++) step(0, one, '0, 0, 0, 0);
        chk("pre_ovf_val", PW'(ctr(2)), PW'(16'hFFFF));
        step(0, one, '0, 0, 0, 0);
        chk("ovf_val", PW'(ctr(2)), SAT ? PW'(16'hFFFF) : PW'(0));
        chk("ovf_flag", PW'(ovf[2]), PW'(1));
        step(0, '0, one, 0, 0, 0);
        chk("ovf_clr", PW'(ovf[2]), PW'(0));

        // Clear-all sweep with counter 0 still counting, plus an ignored re-trigger
        step(1, '0, '0, 0, 0, 0);
        for (int k = 0; k < 10; k++) step(0, allv, '0, 0, 0, 0);
        step(0, N'(1), '0, 1, 0, 0);
        nb = busy ? 1 : 0;
        for (int k = 0; k < 20 && busy; k++) begin
            step(0, N'(1), '0, (k == 3), 0, 0);
            if (busy) nb++;
        end
        chk("sweep_len", PW'(nb), PW'(9));
        chk("sweep_ctr0", PW'(ctr(0)), PW'(8));

        // Snapshot captures pre-update values and survives a clear-all
        step(1, '0, '0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, allv, '0, 0, 0, 0);
        step(0, allv, '0, 0, 0, 1);
        chk("snap_vals", snap_out, {N{16'd4}});
        chk("snap_live", count_out, {N{16'd5}});
        chk("snap_pulse", PW'(snap_valid), PW'(1));
        step(0, '0, '0, 0, 0, 0);
        chk("snap_drop", PW'(snap_valid), PW'(0));
        snap_hold = snap_out;
        step(0, '0, '0, 1, 0, 0);
        for (int k = 0; k < 10; k++) step(0, '0, '0, 0, 0, 0);
        chk("snap_keep", snap_out, {N{16'd4}});
        chk("snap_hold", snap_out, snap_hold);

        // Freeze suppresses increments; reset aborts a sweep
        for (int k = 0; k < 4; k++) step(0, allv, '0, 0, 0, 0);
        for (int k = 0; k < 10; k++) step(0, allv, '0, 0, 1, 0);
        chk("freeze_vals", count_out, {N{16'd4}});
        step(0, '0, '0, 1, 0, 0);
        for (int k = 0; k < 3; k++) step(0, allv, '0, 0, 0, 0);
        step(1, allv, '0, 0, 0, 0);
        chk("rst_busy", PW'(busy), PW'(0));
        chk("rst_cnts", count_out, '0);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] clr;
            clr = '0;
            for (int i = 0; i < N; i++) clr[i] = ($urandom_range(0, 15) == 0);
            step(($urandom_range(0, 299) == 0), N'($urandom), clr,
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
